// File: rtl/cgra_run_ctrl.sv
// rtl/cgra_run_ctrl.sv - run controller sequencing the CGRA start/done handshake per kernel iteration
//
// Purpose: accepts a run command (iteration count + per-phase watchdog limit),
// drives the four-phase Computation_Start/Computation_Done handshake once per
// iteration, and reports progress, elapsed cycles and error/abort status.
//
// Ports:
//   Clk, Resetn          clock, asynchronous active-low reset
//   Cmd_Valid/Cmd_Ready  command handshake; Cmd_Ready high only in IDLE
//   Cmd_Iter             iterations to run (0 legal)
//   Cmd_Timeout          per-phase watchdog limit in cycles (0 = disabled)
//   Abort                host abort request, level sampled
//   Computation_Start    handshake request to the CGRA
//   Computation_Done     handshake acknowledge from the CGRA
//   Run_Busy             high in every state but IDLE
//   Run_Done             one-cycle pulse at run end (normal, error or abort)
//   Run_Error            sticky: last run ended by watchdog expiry
//   Run_Aborted          sticky: last run ended by Abort
//   Iter_Done            iterations completed in current/last run
//   Cycle_Count          saturating count of non-IDLE cycles in current/last run
module cgra_run_ctrl #(
  parameter int ITER_WIDTH = 16,
  parameter int TMO_WIDTH  = 24,
  parameter int CYC_WIDTH  = 32
) (
  input  logic                  Clk,
  input  logic                  Resetn,
  input  logic                  Cmd_Valid,
  output logic                  Cmd_Ready,
  input  logic [ITER_WIDTH-1:0] Cmd_Iter,
  input  logic [TMO_WIDTH-1:0]  Cmd_Timeout,
  input  logic                  Abort,
  output logic                  Computation_Start,
  input  logic                  Computation_Done,
  output logic                  Run_Busy,
  output logic                  Run_Done,
  output logic                  Run_Error,
  output logic                  Run_Aborted,
  output logic [ITER_WIDTH-1:0] Iter_Done,
  output logic [CYC_WIDTH-1:0]  Cycle_Count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ASSERT  = 3'd1,
    RELEASE = 3'd2,
    DRAIN   = 3'd3,
    FIN     = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  start_q, start_d;
  logic                  err_q, err_d;
  logic                  abt_q, abt_d;
  logic [ITER_WIDTH-1:0] iter_q, iter_d;
  logic [ITER_WIDTH-1:0] tgt_q, tgt_d;
  logic [ITER_WIDTH-1:0] iter_inc;
  logic [CYC_WIDTH-1:0]  cyc_q, cyc_d;
  logic [TMO_WIDTH-1:0]  lim_q, lim_d;
  logic [TMO_WIDTH-1:0]  wdog_q, wdog_d;
  logic                  wdog_expire;

  // The watchdog is reloaded with the limit on phase entry and counts down
  // once per cycle the awaited level is missing; reaching 1 while still
  // missing means this is the limit-th such cycle.
  assign wdog_expire = (lim_q != '0) && (wdog_q == TMO_WIDTH'(1));

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      abt_q   <= 1'b0;
      iter_q  <= '0;
      tgt_q   <= '0;
      cyc_q   <= '0;
      lim_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      err_q   <= err_d;
      abt_q   <= abt_d;
      iter_q  <= iter_d;
      tgt_q   <= tgt_d;
      cyc_q   <= cyc_d;
      lim_q   <= lim_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    err_d    = err_q;
    abt_d    = abt_q;
    iter_d   = iter_q;
    tgt_d    = tgt_q;
    lim_d    = lim_q;
    wdog_d   = wdog_q;
    cyc_d    = cyc_q;
    iter_inc = iter_q + ITER_WIDTH'(1);

    if ((state_q != IDLE) && (cyc_q != '1)) begin
      cyc_d = cyc_q + CYC_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        // Abort is deliberately not looked at here.
        if (Cmd_Valid) begin
          tgt_d  = Cmd_Iter;
          lim_d  = Cmd_Timeout;
          wdog_d = Cmd_Timeout;
          iter_d = '0;
          cyc_d  = '0;
          err_d  = 1'b0;
          abt_d  = 1'b0;
          if (Cmd_Iter == '0) begin
            state_d = FIN;
          end else begin
            state_d = ASSERT;
            start_d = 1'b1;
          end
        end
      end

      ASSERT: begin
        if (Abort) begin
          abt_d   = 1'b1;
          start_d = 1'b0;
          state_d = DRAIN;
        end else if (Computation_Done) begin
          start_d = 1'b0;
          wdog_d  = lim_q;
          state_d = RELEASE;
        end else if (wdog_expire) begin
          err_d   = 1'b1;
          start_d = 1'b0;
          state_d = DRAIN;
        end else begin
          wdog_d  = wdog_q - TMO_WIDTH'(1);
        end
      end

      RELEASE: begin
        if (Abort) begin
          abt_d   = 1'b1;
          state_d = DRAIN;
        end else if (!Computation_Done) begin
          iter_d = iter_inc;
          if (iter_inc == tgt_q) begin
            state_d = FIN;
          end else begin
            // Done is known low on this edge, so re-raising Start is safe.
            start_d = 1'b1;
            wdog_d  = lim_q;
            state_d = ASSERT;
          end
        end else if (wdog_expire) begin
          err_d   = 1'b1;
          state_d = DRAIN;
        end else begin
          wdog_d  = wdog_q - TMO_WIDTH'(1);
        end
      end

      DRAIN: begin
        // Wait for the CGRA to drop Done so the next run starts clean.
        if (!Computation_Done) begin
          state_d = FIN;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        start_d = 1'b0;
      end
    endcase
  end

  assign Cmd_Ready         = (state_q == IDLE);
  assign Run_Busy          = (state_q != IDLE);
  assign Run_Done          = (state_q == FIN);
  assign Computation_Start = start_q;
  assign Run_Error         = err_q;
  assign Run_Aborted       = abt_q;
  assign Iter_Done         = iter_q;
  assign Cycle_Count       = cyc_q;

endmodule
